ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one 64x8 single-port RAM between two requesters, A and B.
- Grants at most one access per cycle using round-robin priority, with an optional per-requester lock for back-to-back bursts.
- Drives the RAM's data/addr/write_enable pins and routes read data back to whichever requester issued the read.
- Sits between two client engines (e.g. a DMA fill path and a CPU-side reader) and one external single_port_ram instance.

Parameters:
- AW, 6, address width (RAM depth 2**AW).
- DW, 8, data width.
- RD_LAT, 1, cycles from the RAM address-sampling edge to the RAM read data being valid. Legal values 1..2; other values are a generate-time error.

Ports:
- clk  in  1  single clock, all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  A requests an access this cycle.
- a_we  in  1  1 = write, 0 = read.
- a_lock  in  1  keep priority after this grant.
- a_addr  in  AW  A address.
- a_wdata  in  DW  A write data.
- a_gnt  out  1  combinational; A's access is issued this cycle.
- a_rvalid  out  1  registered; a_rdata is valid this cycle.
- a_rdata  out  DW  registered read data for A.
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for B.
- mem_addr  out  AW  to RAM addr.
- mem_wdata  out  DW  to RAM data.
- mem_we  out  1  to RAM write_enable.
- mem_rdata  in  DW  from RAM read.

Behaviour:
- Reset (asynchronous, active-high): prio=A, lock_owner=NONE, tag pipeline cleared, a/b_rvalid=0, a/b_rdata=0. While rst=1, a_gnt=b_gnt=mem_we=0.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees gnt=1 in the same cycle; the access completes at that cycle's rising edge.
  - req may be dropped at any time before it is granted.
- Grant rule (combinational):
  - If lock_owner=X and X_req=1, grant X.
  - Otherwise, if only one requester has req=1, grant it.
  - If both have req=1, grant prio.
  - Exactly zero or one gnt is high per cycle.
- Priority update at each edge with a grant: prio <= the other requester. The update is also applied to locked grants, so the last grant of a lock sequence is followed by the other side.
- Lock:
  - On a grant with X_lock=1: lock_owner <= X.
  - On a grant with X_lock=0, or on a cycle where lock_owner=X and X_req=0: lock_owner <= NONE.
  - A lock never survives an idle cycle of its owner.
- Mem mux: mem_addr/mem_wdata follow the granted requester (A when none is granted). mem_we = gnt & we of the granted requester, else 0.
- Idle cycles: mem_we=0. The RAM then samples addr and updates its read register, which is harmless.
- Read return:
  - Tag {valid, owner} enters a RD_LAT-deep shift register at each read grant.
  - When the tag at stage RD_LAT is valid, the owner's rdata <= mem_rdata and its rvalid <= 1 for one cycle. The other requester's rvalid is 0.
  - Total latency: grant in cycle T gives rvalid in cycle T+RD_LAT+1.
  - Back-to-back reads pipeline at one result per cycle, returned in grant order.
- Write: no response. A read granted in the cycle after a write to the same address returns the new data.
- rdata holds its last value when rvalid=0.
- Reset mid-operation: in-flight tags are discarded and no rvalid is produced afterwards. RAM contents are untouched (the RAM has no reset).

Decomposition:
- Package ram_arb_pkg holds:
  - AW/DW defaults;
  - owner encoding OWN_NONE=2'b00, OWN_A=2'b01, OWN_B=2'b10;
  - tag struct {valid, owner}.
- One sub-module, ram_rd_return_pipe (parameter RD_LAT): tag shift register plus the rdata/rvalid capture registers.
- Grant logic, prio and lock live in the top module.

Test Plan:
1. Reset: assert rst with a_req=b_req=1 → a_gnt=b_gnt=mem_we=0 and rvalid=0. After release, the first contested cycle grants A.
2. Contention: a_req=b_req=1 reads held for 4 cycles → grants A,B,A,B, with rvalids in the same order RD_LAT+1 cycles later.
3. Write/read: A writes 8'h5A to addr 6'h03; next cycle B reads 6'h03 → b_rvalid=1 with b_rdata=8'h5A in cycle T+2 (RD_LAT=1). a_rvalid stays 0.
4. Lock: A holds a_lock=1 for 3 writes with b_req=1 throughout → A granted 3 cycles, then B granted when a_lock drops. B waits exactly 3 cycles.
5. Reset mid-read: grant a read of 6'h3F, assert rst the next cycle → no a_rvalid ever appears. RAM word 6'h3F still reads its old value after reset.
6. RD_LAT=2 build: back-to-back reads of 6'h00..6'h03 by B → four consecutive b_rvalid cycles starting at T+3, data in address order.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned AW_DEF = 6;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/ram_rd_return_pipe.sv
// Read-tag delay line matching RAM read latency, plus per-requester
// read data / valid capture registers.
module ram_rd_return_pipe
  import ram_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned DW     = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  rd_tag_t       tag_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          a_rvalid_o,
  output logic [DW-1:0] a_rdata_o,
  output logic          b_rvalid_o,
  output logic [DW-1:0] b_rdata_o
);

  if (RD_LAT == 0 || RD_LAT > 2) begin : g_bad_rd_lat
    $error("ram_rd_return_pipe: RD_LAT must be 1 or 2");
  end

  rd_tag_t       tag_q [RD_LAT];
  rd_tag_t       out_tag;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LAT); i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_i;
      for (int i = 1; i < int'(RD_LAT); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign out_tag = tag_q[RD_LAT-1];

  // Tag at the last stage lines up with valid RAM read data.
  always_comb begin
    a_rvalid_d = out_tag.valid && (out_tag.owner == OWN_A);
    b_rvalid_d = out_tag.valid && (out_tag.owner == OWN_B);
    a_rdata_d  = a_rvalid_d ? mem_rdata_i : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? mem_rdata_i : b_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a_rvalid_o = a_rvalid_q;
  assign a_rdata_o  = a_rdata_q;
  assign b_rvalid_o = b_rvalid_q;
  assign b_rdata_o  = b_rdata_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with burst lock sharing one single-port RAM
// between requesters A and B; read data is routed back by tag.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  owner_e  prio_q, prio_d;
  owner_e  lock_q, lock_d;
  logic    gnt_a, gnt_b;
  rd_tag_t tag_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= OWN_A;
      lock_q <= OWN_NONE;
    end else begin
      prio_q <= prio_d;
      lock_q <= lock_d;
    end
  end

  // Grant: lock owner first, then sole requester, then round-robin priority.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst) begin
      if (lock_q == OWN_A && a_req) begin
        gnt_a = 1'b1;
      end else if (lock_q == OWN_B && b_req) begin
        gnt_b = 1'b1;
      end else if (a_req && b_req) begin
        gnt_a = (prio_q == OWN_A);
        gnt_b = (prio_q != OWN_A);
      end else begin
        gnt_a = a_req;
        gnt_b = b_req;
      end
    end
  end

  // A lock is released as soon as its owner goes idle for one cycle.
  always_comb begin
    prio_d = prio_q;
    lock_d = lock_q;
    if ((lock_q == OWN_A && !a_req) || (lock_q == OWN_B && !b_req)) begin
      lock_d = OWN_NONE;
    end
    if (gnt_a) begin
      prio_d = OWN_B;
      lock_d = a_lock ? OWN_A : OWN_NONE;
    end else if (gnt_b) begin
      prio_d = OWN_A;
      lock_d = b_lock ? OWN_B : OWN_NONE;
    end
  end

  always_comb begin
    mem_addr    = gnt_b ? b_addr : a_addr;
    mem_wdata   = gnt_b ? b_wdata : a_wdata;
    mem_we      = (gnt_a && a_we) || (gnt_b && b_we);
    tag_d.valid = (gnt_a && !a_we) || (gnt_b && !b_we);
    tag_d.owner = OWN_NONE;
    if (tag_d.valid) begin
      tag_d.owner = gnt_b ? OWN_B : OWN_A;
    end
  end

  assign a_gnt = gnt_a;
  assign b_gnt = gnt_b;

  ram_rd_return_pipe #(
    .RD_LAT (RD_LAT),
    .DW     (DW)
  ) u_rd_return (
    .clk         (clk),
    .rst         (rst),
    .tag_i       (tag_d),
    .mem_rdata_i (mem_rdata),
    .a_rvalid_o  (a_rvalid),
    .a_rdata_o   (a_rdata),
    .b_rvalid_o  (b_rvalid),
    .b_rdata_o   (b_rdata)
  );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: RD_LAT=1 and RD_LAT=2 arbiters driven by shared stimulus,
// each with its own behavioural single-port RAM.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [5:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;

  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [5:0] m1_addr;
  logic [7:0] m1_wdata, m1_rdata;
  logic       m1_we;

  logic       d2_a_gnt, d2_b_gnt, d2_a_rvalid, d2_b_rvalid;
  logic [7:0] d2_a_rdata, d2_b_rdata;
  logic [5:0] m2_addr;
  logic [7:0] m2_wdata, m2_rdata;
  logic       m2_we;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(6), .DW(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_we(m1_we), .mem_rdata(m1_rdata)
  );

  ram_port_arbiter #(.AW(6), .DW(8), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(d2_a_gnt), .a_rvalid(d2_a_rvalid), .a_rdata(d2_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(d2_b_gnt), .b_rvalid(d2_b_rvalid), .b_rdata(d2_b_rdata),
    .mem_addr(m2_addr), .mem_wdata(m2_wdata), .mem_we(m2_we), .mem_rdata(m2_rdata)
  );

  // Single-port RAMs: read register sampled every edge, optional output stage.
  logic [7:0] ram1 [64];
  logic [7:0] ram1_rd;
  logic [7:0] ram2 [64];
  logic [7:0] ram2_rd_a, ram2_rd_b;

  always @(posedge clk) begin
    if (m1_we) ram1[m1_addr] <= m1_wdata;
    ram1_rd <= ram1[m1_addr];
    if (m2_we) ram2[m2_addr] <= m2_wdata;
    ram2_rd_a <= ram2[m2_addr];
    ram2_rd_b <= ram2_rd_a;
  end
  assign m1_rdata = ram1_rd;
  assign m2_rdata = ram2_rd_b;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic req, input logic we, input logic lock,
                       input logic [5:0] addr, input logic [7:0] wdata);
    a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic set_b(input logic req, input logic we, input logic lock,
                       input logic [5:0] addr, input logic [7:0] wdata);
    b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = wdata;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with both sides requesting writes
    set_a(1'b1, 1'b1, 1'b0, 6'h00, 8'h11);
    set_b(1'b1, 1'b1, 1'b0, 6'h01, 8'h22);
    tick();
    mid();
    chk1("rst_agnt", a_gnt, 1'b0);
    chk1("rst_bgnt", b_gnt, 1'b0);
    chk1("rst_mem_we", m1_we, 1'b0);
    chk1("rst_arvalid", a_rvalid, 1'b0);
    chk1("rst_brvalid", b_rvalid, 1'b0);
    chk8("rst_ardata", a_rdata, 8'h00);
    tick();
    rst = 1'b0;

    // C1: first contested cycle grants A
    mid();
    chk1("c1_agnt", a_gnt, 1'b1);
    chk1("c1_bgnt", b_gnt, 1'b0);
    chk1("c1_mem_we", m1_we, 1'b1);
    chk8("c1_mem_addr", 8'(m1_addr), 8'h00);
    chk8("c1_mem_wdata", m1_wdata, 8'h11);
    tick();
    // C2: B holds, prio now B
    set_a(1'b1, 1'b1, 1'b0, 6'h02, 8'h33);
    mid();
    chk1("c2_bgnt", b_gnt, 1'b1);
    chk1("c2_agnt", a_gnt, 1'b0);
    chk8("c2_mem_addr", 8'(m1_addr), 8'h01);
    chk8("c2_mem_wdata", m1_wdata, 8'h22);
    tick();
    // C3: A wins back
    set_b(1'b1, 1'b1, 1'b0, 6'h3F, 8'hC3);
    mid();
    chk1("c3_agnt", a_gnt, 1'b1);
    chk8("c3_mem_addr", 8'(m1_addr), 8'h02);
    tick();
    // C4: sole requester B
    set_a(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    mid();
    chk1("c4_bgnt", b_gnt, 1'b1);
    chk8("c4_mem_addr", 8'(m1_addr), 8'h3F);
    tick();

    // Contended reads: grants A,B,A,B
    set_a(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
    set_b(1'b1, 1'b0, 1'b0, 6'h01, 8'h00);
    mid();
    chk1("r1_agnt", a_gnt, 1'b1);
    chk1("r1_bgnt", b_gnt, 1'b0);
    chk1("r1_mem_we", m1_we, 1'b0);
    tick();
    set_a(1'b1, 1'b0, 1'b0, 6'h02, 8'h00);
    mid();
    chk1("r2_bgnt", b_gnt, 1'b1);
    chk1("r2_agnt", a_gnt, 1'b0);
    tick();
    set_b(1'b1, 1'b0, 1'b0, 6'h3F, 8'h00);
    mid();
    chk1("r3_agnt", a_gnt, 1'b1);
    chk1("r3_arvalid", a_rvalid, 1'b1);
    chk8("r3_ardata", a_rdata, 8'h11);
    chk1("r3_brvalid", b_rvalid, 1'b0);
    tick();
    set_a(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
    mid();
    chk1("r4_bgnt", b_gnt, 1'b1);
    chk1("r4_agnt", a_gnt, 1'b0);
    chk1("r4_brvalid", b_rvalid, 1'b1);
    chk8("r4_brdata", b_rdata, 8'h22);
    chk1("r4_arvalid", a_rvalid, 1'b0);
    tick();
    set_a(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    set_b(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    mid();
    chk1("r5_arvalid", a_rvalid, 1'b1);
    chk8("r5_ardata", a_rdata, 8'h33);
    chk1("r5_brvalid", b_rvalid, 1'b0);
    tick();
    mid();
    chk1("r6_brvalid", b_rvalid, 1'b1);
    chk8("r6_brdata", b_rdata, 8'hC3);
    chk1("r6_arvalid", a_rvalid, 1'b0);
    chk8("r6_ardata_hold", a_rdata, 8'h33);
    tick();
    mid();
    chk1("r7_brvalid", b_rvalid, 1'b0);
    chk8("r7_brdata_hold", b_rdata, 8'hC3);
    tick();

    // Write then read-after-write from the other side
    set_a(1'b1, 1'b1, 1'b0, 6'h03, 8'h5A);
    mid();
    chk1("w_agnt", a_gnt, 1'b1);
    chk1("w_mem_we", m1_we, 1'b1);
    chk8("w_mem_addr", 8'(m1_addr), 8'h03);
    tick();
    set_a(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    set_b(1'b1, 1'b0, 1'b0, 6'h03, 8'h00);
    mid();
    chk1("raw_bgnt", b_gnt, 1'b1);
    chk1("raw_mem_we", m1_we, 1'b0);
    tick();
    set_b(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    mid();
    chk1("raw_t1_brvalid", b_rvalid, 1'b0);
    tick();
    mid();
    chk1("raw_t2_brvalid", b_rvalid, 1'b1);
    chk8("raw_t2_brdata", b_rdata, 8'h5A);
    chk1("raw_t2_arvalid", a_rvalid, 1'b0);
    tick();

    // Locked burst of 3 writes by A while B waits
    set_b(1'b1, 1'b0, 1'b0, 6'h10, 8'h00);
    set_a(1'b1, 1'b1, 1'b1, 6'h10, 8'h71);
    mid();
    chk1("l1_agnt", a_gnt, 1'b1);
    tick();
    set_a(1'b1, 1'b1, 1'b1, 6'h11, 8'h72);
    mid();
    chk1("l2_agnt", a_gnt, 1'b1);
    chk1("l2_bgnt", b_gnt, 1'b0);
    tick();
    set_a(1'b1, 1'b1, 1'b1, 6'h12, 8'h73);
    mid();
    chk1("l3_agnt", a_gnt, 1'b1);
    chk1("l3_bgnt", b_gnt, 1'b0);
    tick();
    set_a(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    mid();
    chk1("l4_bgnt", b_gnt, 1'b1);
    chk1("l4_agnt", a_gnt, 1'b0);
    tick();
    set_b(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    tick();
    mid();
    chk1("l6_brvalid", b_rvalid, 1'b1);
    chk8("l6_brdata", b_rdata, 8'h71);
    tick();

    // Reset while a read of 3F is in flight
    set_a(1'b1, 1'b0, 1'b0, 6'h3F, 8'h00);
    mid();
    chk1("m1_agnt", a_gnt, 1'b1);
    tick();
    rst = 1'b1;
    mid();
    chk1("m2_agnt_rst", a_gnt, 1'b0);
    chk1("m2_arvalid", a_rvalid, 1'b0);
    tick();
    rst = 1'b0;
    set_a(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    mid();
    chk1("m3_arvalid", a_rvalid, 1'b0);
    chk8("m3_ardata", a_rdata, 8'h00);
    tick();
    mid();
    chk1("m4_arvalid", a_rvalid, 1'b0);
    tick();
    set_a(1'b1, 1'b0, 1'b0, 6'h3F, 8'h00);
    mid();
    chk1("m5_agnt", a_gnt, 1'b1);
    tick();
    set_a(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    mid();
    chk1("m6_arvalid", a_rvalid, 1'b0);
    tick();
    mid();
    chk1("m7_arvalid", a_rvalid, 1'b1);
    chk8("m7_ardata", a_rdata, 8'hC3);
    tick();

    // Back-to-back B reads of 00..03 on both latencies
    set_b(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
    mid();
    chk1("q1_d2_bgnt", d2_b_gnt, 1'b1);
    tick();
    set_b(1'b1, 1'b0, 1'b0, 6'h01, 8'h00);
    mid();
    chk1("q2_d2_bgnt", d2_b_gnt, 1'b1);
    chk1("q2_d2_brvalid", d2_b_rvalid, 1'b0);
    tick();
    set_b(1'b1, 1'b0, 1'b0, 6'h02, 8'h00);
    mid();
    chk1("q3_d2_bgnt", d2_b_gnt, 1'b1);
    chk1("q3_d2_brvalid", d2_b_rvalid, 1'b0);
    chk1("q3_brvalid", b_rvalid, 1'b1);
    chk8("q3_brdata", b_rdata, 8'h11);
    tick();
    set_b(1'b1, 1'b0, 1'b0, 6'h03, 8'h00);
    mid();
    chk1("q4_d2_bgnt", d2_b_gnt, 1'b1);
    chk1("q4_d2_brvalid", d2_b_rvalid, 1'b1);
    chk8("q4_d2_brdata", d2_b_rdata, 8'h11);
    chk8("q4_brdata", b_rdata, 8'h22);
    tick();
    set_b(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    mid();
    chk1("q5_d2_brvalid", d2_b_rvalid, 1'b1);
    chk8("q5_d2_brdata", d2_b_rdata, 8'h22);
    chk8("q5_brdata", b_rdata, 8'h33);
    tick();
    mid();
    chk1("q6_d2_brvalid", d2_b_rvalid, 1'b1);
    chk8("q6_d2_brdata", d2_b_rdata, 8'h33);
    chk1("q6_brvalid", b_rvalid, 1'b1);
    chk8("q6_brdata", b_rdata, 8'h5A);
    tick();
    mid();
    chk1("q7_d2_brvalid", d2_b_rvalid, 1'b1);
    chk8("q7_d2_brdata", d2_b_rdata, 8'h5A);
    chk1("q7_brvalid", b_rvalid, 1'b0);
    chk1("q7_d2_arvalid", d2_a_rvalid, 1'b0);
    tick();
    mid();
    chk1("q8_d2_brvalid", d2_b_rvalid, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
